// File: rtl/img_pkg.sv
// Shared image-path definitions for the 3x3 window generator and the median filter.
// Window rows are packed with the oldest column (x-1) in the low slice and the newest (x+1) on top.
package img_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int WIN_TAPS   = 3;

    typedef logic [DATA_W_DEF-1:0] pixel_t;

endpackage

// File: rtl/line_buffer.sv
// Single-port line store: one address per access, registered read data,
// and the read returns the word as it was before a same-cycle write.
module line_buffer
    import img_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 640,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto block RAM; every row is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/window_gen3x3.sv
// Raster-to-window generator: buffers two lines and emits the 3x3 neighbourhood
// of every interior pixel, two cycles after the pixel that completes it.
module window_gen3x3
    import img_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    localparam int XW    = $clog2(IMG_W),
    localparam int YW    = $clog2(IMG_H),
    localparam int ROW_W = WIN_TAPS * DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              sof,
    output logic [ROW_W-1:0]  win_top,
    output logic [ROW_W-1:0]  win_mid,
    output logic [ROW_W-1:0]  win_bot,
    output logic              win_valid,
    output logic [XW-1:0]     win_x,
    output logic [YW-1:0]     win_y
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_FULL = XW'(2);
    localparam logic [YW-1:0] Y_FULL = YW'(2);

    typedef struct packed {
        logic [DATA_W-1:0] top;
        logic [DATA_W-1:0] mid;
        logic [DATA_W-1:0] bot;
    } column_t;

    logic              accept;
    logic [XW-1:0]     x_cur;
    logic [YW-1:0]     y_cur;
    logic [DATA_W-1:0] lb_even_rd;
    logic [DATA_W-1:0] lb_odd_rd;

    logic [XW-1:0]     col_cnt_q, col_cnt_d;
    logic [YW-1:0]     row_cnt_q, row_cnt_d;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_pix_q, s1_pix_d;
    logic [XW-1:0]     s1_x_q, s1_x_d;
    logic [YW-1:0]     s1_y_q, s1_y_d;

    logic              s2_valid_q, s2_valid_d;
    column_t           s2_col_q, s2_col_d;
    logic [XW-1:0]     s2_x_q, s2_x_d;
    logic [YW-1:0]     s2_y_q, s2_y_d;

    column_t           hist_new_q, hist_new_d;
    column_t           hist_old_q, hist_old_d;

    logic [ROW_W-1:0]  win_top_q, win_top_d;
    logic [ROW_W-1:0]  win_mid_q, win_mid_d;
    logic [ROW_W-1:0]  win_bot_q, win_bot_d;
    logic              win_valid_q, win_valid_d;
    logic [XW-1:0]     win_x_q, win_x_d;
    logic [YW-1:0]     win_y_q, win_y_d;

    assign accept = pix_valid;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        x_cur     = (accept && sof) ? '0 : col_cnt_q;
        y_cur     = (accept && sof) ? '0 : row_cnt_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (accept) begin
            if (x_cur == X_LAST) begin
                col_cnt_d = '0;
                row_cnt_d = (y_cur == Y_LAST) ? '0 : y_cur + 1'b1;
            end else begin
                col_cnt_d = x_cur + 1'b1;
                row_cnt_d = y_cur;
            end
        end
    end

    // Two line stores alternate by row parity: the store matching row y holds y-2,
    // is read before row y overwrites it, and the other store holds y-1.
    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb_even (
        .clk   (clk),
        .en    (accept),
        .we    (accept && !y_cur[0]),
        .addr  (x_cur),
        .wdata (pix_in),
        .rdata (lb_even_rd)
    );

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb_odd (
        .clk   (clk),
        .en    (accept),
        .we    (accept && y_cur[0]),
        .addr  (x_cur),
        .wdata (pix_in),
        .rdata (lb_odd_rd)
    );

    always_comb begin
        s1_valid_d = accept;
        s1_pix_d   = s1_pix_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        if (accept) begin
            s1_pix_d = pix_in;
            s1_x_d   = x_cur;
            s1_y_d   = y_cur;
        end
    end

    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_col_d   = s2_col_q;
        s2_x_d     = s2_x_q;
        s2_y_d     = s2_y_q;
        if (s1_valid_q) begin
            s2_col_d.top = s1_y_q[0] ? lb_odd_rd  : lb_even_rd;
            s2_col_d.mid = s1_y_q[0] ? lb_even_rd : lb_odd_rd;
            s2_col_d.bot = s1_pix_q;
            s2_x_d       = s1_x_q;
            s2_y_d       = s1_y_q;
        end
    end

    // Column history shifts on every tagged column, so the previous line's
    // columns are gone by the time a row reaches x=2.
    always_comb begin
        hist_new_d  = hist_new_q;
        hist_old_d  = hist_old_q;
        win_valid_d = s2_valid_q && (s2_x_q >= X_FULL) && (s2_y_q >= Y_FULL);
        win_top_d   = win_top_q;
        win_mid_d   = win_mid_q;
        win_bot_d   = win_bot_q;
        win_x_d     = win_x_q;
        win_y_d     = win_y_q;
        if (s2_valid_q) begin
            hist_new_d = s2_col_q;
            hist_old_d = hist_new_q;
        end
        if (win_valid_d) begin
            win_top_d = {s2_col_q.top, hist_new_q.top, hist_old_q.top};
            win_mid_d = {s2_col_q.mid, hist_new_q.mid, hist_old_q.mid};
            win_bot_d = {s2_col_q.bot, hist_new_q.bot, hist_old_q.bot};
            win_x_d   = s2_x_q - XW'(1);
            win_y_d   = s2_y_q - YW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_pix_q    <= '0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_col_q    <= '0;
            s2_x_q      <= '0;
            s2_y_q      <= '0;
            hist_new_q  <= '0;
            hist_old_q  <= '0;
            win_top_q   <= '0;
            win_mid_q   <= '0;
            win_bot_q   <= '0;
            win_valid_q <= 1'b0;
            win_x_q     <= '0;
            win_y_q     <= '0;
        end else begin
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_pix_q    <= s1_pix_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s2_valid_q  <= s2_valid_d;
            s2_col_q    <= s2_col_d;
            s2_x_q      <= s2_x_d;
            s2_y_q      <= s2_y_d;
            hist_new_q  <= hist_new_d;
            hist_old_q  <= hist_old_d;
            win_top_q   <= win_top_d;
            win_mid_q   <= win_mid_d;
            win_bot_q   <= win_bot_d;
            win_valid_q <= win_valid_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
        end
    end

    assign win_top   = win_top_q;
    assign win_mid   = win_mid_q;
    assign win_bot   = win_bot_q;
    assign win_valid = win_valid_q;
    assign win_x     = win_x_q;
    assign win_y     = win_y_q;

endmodule

// File: tb/tb_window_gen3x3.sv
// Bench for window_gen3x3: a 5x4 instance driven by randomized raster traffic against an
// image-array reference model, plus a 3x3 instance for the single-window corner case.
module tb_window_gen3x3;
    import img_pkg::*;

    localparam int W = 5;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    pixel_t      pix_in;
    logic        pix_valid, sof;
    logic [23:0] win_top, win_mid, win_bot;
    logic        win_valid;
    logic [2:0]  win_x;
    logic [1:0]  win_y;

    pixel_t      s_pix_in;
    logic        s_pix_valid, s_sof;
    logic [23:0] s_win_top, s_win_mid, s_win_bot;
    logic        s_win_valid;
    logic [1:0]  s_win_x, s_win_y;

    window_gen3x3 #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .win_top(win_top), .win_mid(win_mid), .win_bot(win_bot),
        .win_valid(win_valid), .win_x(win_x), .win_y(win_y)
    );

    window_gen3x3 #(.DATA_W(8), .IMG_W(3), .IMG_H(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .pix_in(s_pix_in), .pix_valid(s_pix_valid), .sof(s_sof),
        .win_top(s_win_top), .win_mid(s_win_mid), .win_bot(s_win_bot),
        .win_valid(s_win_valid), .win_x(s_win_x), .win_y(s_win_y)
    );

    always #5 clk = ~clk;

    int unsigned edges = 0;
    always @(posedge clk) edges++;

    typedef struct {
        logic [71:0] data;
        logic [2:0]  x;
        logic [1:0]  y;
        int unsigned due;
    } win_t;

    win_t        exp_q[$];
    pixel_t      img [H][W];
    int          mx, my;
    int          n_tests = 0;
    int          n_fail = 0;
    int          strobes;
    logic [71:0] hold_win;
    logic [4:0]  hold_xy;
    logic [71:0] first_win, last_win;
    logic [4:0]  first_xy, last_xy;
    int unsigned first_edge, acc_22;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: store each accepted pixel in a frame image and, for interior
    // completing pixels, predict the full neighbourhood two edges later.
    task automatic model_accept(input logic s, input pixel_t p);
        win_t w;
        if (s) begin
            mx = 0;
            my = 0;
        end
        img[my][mx] = p;
        if (p == 8'h22) acc_22 = edges + 1;
        if (mx >= 2 && my >= 2) begin
            w.data = {img[my-2][mx], img[my-2][mx-1], img[my-2][mx-2],
                      img[my-1][mx], img[my-1][mx-1], img[my-1][mx-2],
                      img[my][mx],   img[my][mx-1],   img[my][mx-2]};
            w.x    = 3'(mx - 1);
            w.y    = 2'(my - 1);
            w.due  = edges + 3;
            exp_q.push_back(w);
        end
        mx++;
        if (mx == W) begin
            mx = 0;
            my = (my == H - 1) ? 0 : my + 1;
        end
    endtask

    task automatic step(input logic v, input logic s, input pixel_t p);
        logic exp_v;
        win_t w;
        @(negedge clk);
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == edges);
        check("win_valid", win_valid, exp_v);
        if (win_valid === 1'b1) begin
            strobes++;
            if (strobes == 1) begin
                first_win  = {win_top, win_mid, win_bot};
                first_xy   = {win_x, win_y};
                first_edge = edges;
            end
            last_win = {win_top, win_mid, win_bot};
            last_xy  = {win_x, win_y};
        end
        if (exp_v) begin
            w = exp_q.pop_front();
            check("win_data", {win_top, win_mid, win_bot}, w.data);
            check("win_x", win_x, w.x);
            check("win_y", win_y, w.y);
            hold_win = w.data;
            hold_xy  = {w.x, w.y};
        end else begin
            check("hold_data", {win_top, win_mid, win_bot}, hold_win);
            check("hold_xy", {win_x, win_y}, hold_xy);
        end
        pix_valid = v;
        sof       = s;
        pix_in    = p;
        if (v) model_accept(s, p);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int start, input int n, input bit with_sof,
                              input int pct, input bit rnd);
        for (int i = 0; i < n; i++) begin
            int     pos;
            pixel_t p;
            pos = (start + i) % (W * H);
            p   = rnd ? pixel_t'($urandom) : {4'(pos / W), 4'(pos % W)};
            while ($urandom_range(99, 0) >= pct)
                step(1'b0, 1'($urandom_range(1, 0)), pixel_t'($urandom));
            step(1'b1, with_sof && (i == 0), p);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        pix_valid = 1'b0;
        sof       = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_mid_valid", win_valid, 1'b0);
        check("rst_mid_data", {win_top, win_mid, win_bot}, 72'h0);
        check("rst_mid_xy", {win_x, win_y}, 5'h0);
        exp_q.delete();
        hold_win = '0;
        hold_xy  = '0;
        mx       = 0;
        my       = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned s_acc, s_edge;
        int          s_cnt;
        logic [71:0] s_win;
        logic [3:0]  s_xy;

        pix_in = '0; pix_valid = 1'b0; sof = 1'b0;
        s_pix_in = '0; s_pix_valid = 1'b0; s_sof = 1'b0;
        hold_win = '0; hold_xy = '0; mx = 0; my = 0; acc_22 = 0;
        #2;
        check("rst_valid", win_valid, 1'b0);
        check("rst_data", {win_top, win_mid, win_bot}, 72'h0);
        check("rst_xy", {win_x, win_y}, 5'h0);
        check("rst_small_valid", s_win_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        strobes = 0;
        send_frame(0, 20, 1'b1, 100, 1'b0);
        idle(4);
        check("cont_strobes", strobes, 6);
        check("first_win", first_win, 72'h020100_121110_222120);
        check("first_xy", first_xy, {3'd1, 2'd1});
        check("first_latency", first_edge - acc_22, 2);
        check("last_xy", last_xy, {3'd3, 2'd2});
        check("last_bot", last_win[23:0], 24'h343332);

        strobes = 0;
        send_frame(0, 20, 1'b1, 50, 1'b0);
        idle(4);
        check("gap_strobes", strobes, 6);

        strobes = 0;
        send_frame(0, 40, 1'b1, 100, 1'b0);
        idle(4);
        check("b2b_strobes", strobes, 12);

        strobes = 0;
        send_frame(0, 40, 1'b1, 70, 1'b1);
        idle(4);
        check("rand_strobes", strobes, 12);

        strobes = 0;
        send_frame(0, 13, 1'b1, 100, 1'b0);
        send_frame(0, 20, 1'b1, 60, 1'b0);
        idle(4);
        check("sof_mid_strobes", strobes, 7);

        strobes = 0;
        send_frame(0, 12, 1'b1, 100, 1'b0);
        reset_pulse();
        send_frame(0, 20, 1'b0, 100, 1'b0);
        idle(4);
        check("post_rst_strobes", strobes, 6);
        check("model_drained", exp_q.size(), 0);

        s_cnt = 0; s_acc = 0; s_edge = 0; s_win = '0; s_xy = '0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (s_win_valid === 1'b1) begin
                s_cnt++;
                s_win  = {s_win_top, s_win_mid, s_win_bot};
                s_xy   = {s_win_x, s_win_y};
                s_edge = edges;
            end
            s_pix_valid = (i < 9);
            s_sof       = (i == 0);
            s_pix_in    = {4'(i / 3), 4'(i % 3)};
            if (i == 8) s_acc = edges + 1;
        end
        check("small_strobes", s_cnt, 1);
        check("small_xy", s_xy, {2'd1, 2'd1});
        check("small_win", s_win, 72'h020100_121110_222120);
        check("small_latency", s_edge - s_acc, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/window_gen3x3.md
Name: window_gen3x3

Overview:
- Raster-to-window generator that produces the 3x3 pixel neighbourhood consumed by the 3x3 median filter.
- Accepts one pixel per cycle from the video input path and buffers two previous lines.
- Emits three 3-pixel rows plus a window-valid strobe and the centre coordinate.
- Sits directly upstream of the filter; its three row outputs map onto the filter's three row inputs.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 640, active pixels per line; must be at least 3.
- IMG_H, 480, active lines per frame; must be at least 3.
- Derived: XW = clog2(IMG_W), YW = clog2(IMG_H), computed as localparams.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pix_in  in  DATA_W  raster pixel, left-to-right then top-to-bottom.
- pix_valid  in  1  pix_in is accepted on this edge. No backpressure.
- sof  in  1  qualified by pix_valid; marks this pixel as (0,0).
- win_top  out  3*DATA_W  row y-1 of the window; [DATA_W-1:0] = column x-1, top slice = column x+1.
- win_mid  out  3*DATA_W  row y, same packing.
- win_bot  out  3*DATA_W  row y+1, same packing.
- win_valid  out  1  window outputs valid this cycle.
- win_x  out  XW  centre column, 1..IMG_W-2.
- win_y  out  YW  centre row, 1..IMG_H-2.

Behaviour:
- Reset (async assert, sync release): all outputs 0; col_cnt, row_cnt, pipeline valids and window registers 0. Line-buffer contents are not cleared.
- Counters advance only on an accepted pixel. col_cnt wraps IMG_W-1 -> 0 and increments row_cnt. row_cnt wraps IMG_H-1 -> 0, so the next frame starts at (0,0) without sof.
- sof && pix_valid: that pixel is treated as (0,0) whatever the counter values; counters then continue from there.
- Line buffers: two IMG_W-deep memories. lb0 holds line y-1; lb1 holds line y-2.
  - Accepted pixel at column x: read lb0[x] and lb1[x] (read-before-write).
  - Write lb1[x] <= lb0[x] and lb0[x] <= pix_in.
  - Synchronous-read RAM is allowed.
- Pipeline, with the accept edge as cycle N:
  - N+1: RAM data and the delayed pixel/tag are available.
  - N+2 edge: the column shifts into the window registers, and win_valid/win_x/win_y register.
  - Fixed latency: win_valid is high in the cycle after edge N+2.
- The stage-valid tag travels with each accepted pixel. Input gaps (pix_valid=0) insert bubbles only; the window shifts only on tagged columns.
- win_valid = tag && col >= 2 && row >= 2, using the completing pixel's coordinates.
  - Centre: win_x = col-1, win_y = row-1.
  - No border windows are produced: exactly (IMG_W-2)*(IMG_H-2) strobes per frame.
  - Stale columns from the previous line are flushed before col=2, so no explicit clear is needed at line start.
- win_valid is a single-cycle strobe per completing pixel; it is low otherwise. Window data holds its value when win_valid is low.
- Reset mid-frame: the pipeline is discarded and counters restart at (0,0). The first valid window needs two fresh lines.
- sof mid-frame: counters restart; in-flight pipeline entries still complete with their original coordinates.

Decomposition:
- Shared package (img_pkg): DATA_W default, pixel typedef, and the window packing order. The median filter uses the same package.
- One sub-module, line_buffer: a single-port read-before-write RAM of IMG_W x DATA_W with registered read. It is instantiated twice.
- Counters, alignment and window registers stay in the top module.

Test Plan:
- IMG_W=5, IMG_H=4, pixel = {y[3:0],x[3:0]}, continuous valid with sof on the first pixel.
  - Expect exactly 6 strobes.
  - First strobe 2 cycles after pixel 0x22 is accepted: win_top={02,01,00}, win_mid={12,11,10}, win_bot={22,21,20} (MSB..LSB), win_x=1, win_y=1.
  - Last strobe: centre (3,2), bot={34,33,32}.
- Same frame with pix_valid toggling randomly at 50%: identical window sequence, each strobe exactly 2 cycles after its completing pixel.
- Two frames back-to-back with no second sof: second frame's 6 windows identical to the first; no window straddles the frame boundary.
- sof asserted at pixel (3,2) of frame 1: no strobe until new row 2 col 2; following windows use the new coordinates.
- rst_n pulsed low for one cycle mid-row 2: outputs go to 0 asynchronously; after release, a full frame produces exactly 6 correct windows.
- IMG_W=3, IMG_H=3 corner case: exactly one strobe, centre (1,1).
